// File: rtl/cnf_truth_table_sequencer_if.sv
// Host register and CUT signal bundle for the truth-table sequencer.
// master = host/bench side, slave = sequencer side.
interface cnf_truth_table_sequencer_if #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 5
);
   logic             start;
   logic             abort;
   logic             busy;
   logic             done;
   logic [N_IN-1:0]  cut_x;
   logic [N_OUT-1:0] cut_f;
   logic             exp_we;
   logic [N_IN-1:0]  exp_addr;
   logic [N_OUT-1:0] exp_data;
   logic [N_IN-1:0]  rd_addr;
   logic [N_OUT-1:0] rd_data;
   logic [N_IN:0]    mismatch_cnt;
   logic [N_IN-1:0]  first_fail;
   logic             fail_valid;
   logic             pass;

   modport master (
      output start, abort, cut_f,
      output exp_we, exp_addr, exp_data, rd_addr,
      input  busy, done, cut_x, rd_data,
      input  mismatch_cnt, first_fail, fail_valid, pass
   );

   modport slave (
      input  start, abort, cut_f,
      input  exp_we, exp_addr, exp_data, rd_addr,
      output busy, done, cut_x, rd_data,
      output mismatch_cnt, first_fail, fail_valid, pass
   );
endinterface

// File: rtl/cnf_truth_table_sequencer.sv
// Sweeps every input minterm through a combinational CUT and compares
// the sampled outputs against a host-loaded golden truth table.
module cnf_truth_table_sequencer #(
   parameter int N_IN   = 4,
   parameter int N_OUT  = 5,
   parameter int SETTLE = 1
) (
   input logic clk,
   input logic rst,
   cnf_truth_table_sequencer_if.slave bus
);
   localparam int DEPTH = 1 << N_IN;
   localparam int SW    = (SETTLE < 2) ? 1 : $clog2(SETTLE);
   localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
   localparam logic [N_IN-1:0] LAST_IDX    = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SETTLE,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nx;

   logic [N_IN-1:0]  idx;
   logic [SW-1:0]    scnt;
   logic [N_IN-1:0]  cut_x_q;
   logic [N_IN:0]    miss_cnt;
   logic [N_IN-1:0]  ff_idx;
   logic             ff_vld;
   logic             pass_q;
   logic             busy_q;
   logic [N_OUT-1:0] gold [DEPTH];
   logic [N_OUT-1:0] capt [DEPTH];

   logic abort_hit;
   logic miss;

   assign abort_hit = bus.abort && (state != S_IDLE);
   assign miss      = bus.cut_f != gold[idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:    if (bus.start) state_nx = S_APPLY;
         S_APPLY:   state_nx = S_SETTLE;
         S_SETTLE:  if (scnt == SETTLE_LAST) state_nx = S_CAPTURE;
         S_CAPTURE: state_nx = (idx == LAST_IDX) ? S_DONE : S_APPLY;
         S_DONE:    state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
      // abort outranks any capture/done progress this cycle
      if (abort_hit) state_nx = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx      <= '0;
         scnt     <= '0;
         cut_x_q  <= '0;
         miss_cnt <= '0;
         ff_idx   <= '0;
         ff_vld   <= 1'b0;
         pass_q   <= 1'b0;
         busy_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            gold[i] <= '0;
            capt[i] <= '0;
         end
      end else begin
         // golden table frozen while a sweep is in flight
         if (state == S_IDLE && bus.exp_we)
            gold[bus.exp_addr] <= bus.exp_data;
         if (abort_hit) begin
            busy_q <= 1'b0;
            pass_q <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (bus.start) begin
                     idx      <= '0;
                     miss_cnt <= '0;
                     ff_idx   <= '0;
                     ff_vld   <= 1'b0;
                     pass_q   <= 1'b0;
                     busy_q   <= 1'b1;
                  end
               end
               S_APPLY: begin
                  cut_x_q <= idx;
                  scnt    <= '0;
               end
               S_SETTLE: begin
                  if (scnt != SETTLE_LAST)
                     scnt <= scnt + 1'b1;
               end
               S_CAPTURE: begin
                  capt[idx] <= bus.cut_f;
                  if (miss) begin
                     miss_cnt <= miss_cnt + 1'b1;
                     if (!ff_vld) begin
                        ff_idx <= idx;
                        ff_vld <= 1'b1;
                     end
                  end
                  if (idx != LAST_IDX)
                     idx <= idx + 1'b1;
               end
               S_DONE: begin
                  pass_q <= (miss_cnt == '0);
                  busy_q <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = (state == S_DONE) && !bus.abort;
   assign bus.cut_x        = cut_x_q;
   assign bus.rd_data      = capt[bus.rd_addr];
   assign bus.mismatch_cnt = miss_cnt;
   assign bus.first_fail   = ff_idx;
   assign bus.fail_valid   = ff_vld;
   assign bus.pass         = pass_q;

endmodule

// File: tb/tb_cnf_truth_table_sequencer.sv
// Directed bench for cnf_truth_table_sequencer: two instances
// (SETTLE=1 and SETTLE=3) with bench-modelled CUTs.
module tb_cnf_truth_table_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   logic dly_sel = 1'b0;
   logic [4:0] da1 = '0, da2 = '0, db1 = '0, db2 = '0;

   cnf_truth_table_sequencer_if #(.N_IN(4), .N_OUT(5)) ia ();
   cnf_truth_table_sequencer_if #(.N_IN(4), .N_OUT(5)) ib ();

   always #5 clk = ~clk;

   cnf_truth_table_sequencer #(.N_IN(4), .N_OUT(5), .SETTLE(1)) dut_a (
      .clk(clk), .rst(rst), .bus(ia.slave));
   cnf_truth_table_sequencer #(.N_IN(4), .N_OUT(5), .SETTLE(3)) dut_b (
      .clk(clk), .rst(rst), .bus(ib.slave));

   // CUT models: identity f={0,x}, or the same delayed by two cycles
   always @(posedge clk) begin
      da1 <= {1'b0, ia.cut_x};
      da2 <= da1;
      db1 <= {1'b0, ib.cut_x};
      db2 <= db1;
   end
   assign ia.cut_f = dly_sel ? da2 : {1'b0, ia.cut_x};
   assign ib.cut_f = db2;

   task automatic wr(input bit sel, input logic [3:0] a,
                     input logic [4:0] d);
      @(negedge clk);
      if (sel) begin
         ib.exp_we = 1'b1; ib.exp_addr = a; ib.exp_data = d;
      end else begin
         ia.exp_we = 1'b1; ia.exp_addr = a; ia.exp_data = d;
      end
      @(negedge clk);
      ia.exp_we = 1'b0;
      ib.exp_we = 1'b0;
   endtask

   task automatic load_id(input bit sel);
      for (int i = 0; i < 16; i++) wr(sel, 4'(i), 5'(i));
   endtask

   // mode 0 plain, 1 re-start + write at cycle 10, 2 write with start
   task automatic run(input bit sel, input int mode, output int lat,
                      output logic busy0, output logic done_nx);
      @(negedge clk);
      if (sel) ib.start = 1'b1;
      else     ia.start = 1'b1;
      if (mode == 2) begin
         ia.exp_we = 1'b1; ia.exp_addr = 4'd3; ia.exp_data = 5'h1F;
      end
      @(posedge clk);
      #1;
      ia.start = 1'b0; ib.start = 1'b0; ia.exp_we = 1'b0;
      lat = 0;
      @(negedge clk);
      busy0 = sel ? ib.busy : ia.busy;
      while (!(sel ? ib.done : ia.done) && lat < 400) begin
         if (mode == 1 && lat == 10) begin
            ia.start = 1'b1; ia.exp_we = 1'b1;
            ia.exp_addr = 4'd15; ia.exp_data = 5'h1F;
         end else begin
            ia.start = 1'b0; ia.exp_we = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      ia.start = 1'b0; ia.exp_we = 1'b0;
      checks++;
      if (lat >= 400) begin
         failures++;
         $display("FAIL run_timeout sel=%0d got lat=%0d", sel, lat);
      end
      @(negedge clk);
      done_nx = sel ? ib.done : ia.done;
   endtask

   task automatic test_reset();
      int bad;
      repeat (2) @(negedge clk);
      checks++;
      if ({ia.busy, ia.done, ia.cut_x, ia.mismatch_cnt, ia.first_fail,
           ia.fail_valid, ia.pass} !== '0) begin
         failures++;
         $display("FAIL reset_outs busy=%b done=%b x=%h cnt=%0d", ia.busy,
                  ia.done, ia.cut_x, ia.mismatch_cnt);
      end
      bad = 0;
      for (int a = 0; a < 16; a++) begin
         ia.rd_addr = 4'(a);
         #1;
         if (ia.rd_data !== 5'd0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL reset_rd nonzero=%0d exp=0", bad);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat;
      logic b0, dn;
      load_id(0);
      run(0, 0, lat, b0, dn);
      checks++;
      if (lat != 48) begin
         failures++; $display("FAIL basic_lat got=%0d exp=48", lat);
      end
      checks++;
      if (b0 !== 1'b1 || dn !== 1'b0) begin
         failures++; $display("FAIL basic_busy_done busy=%b done_nx=%b", b0, dn);
      end
      checks++;
      if (ia.pass !== 1'b1 || ia.mismatch_cnt !== 5'd0 ||
          ia.fail_valid !== 1'b0 || ia.busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_status pass=%b cnt=%0d fv=%b busy=%b",
                  ia.pass, ia.mismatch_cnt, ia.fail_valid, ia.busy);
      end
      ia.rd_addr = 4'd9;
      #1;
      checks++;
      if (ia.rd_data !== 5'b01001) begin
         failures++; $display("FAIL basic_rd9 got=%b exp=01001", ia.rd_data);
      end
   endtask

   task automatic test_mismatch();
      int lat;
      logic b0, dn;
      wr(0, 4'd5, 5'h1F);
      wr(0, 4'd9, 5'h00);
      run(0, 0, lat, b0, dn);
      checks++;
      if (ia.mismatch_cnt !== 5'd2 || ia.first_fail !== 4'd5 ||
          ia.fail_valid !== 1'b1 || ia.pass !== 1'b0) begin
         failures++;
         $display("FAIL mm_status cnt=%0d ff=%0d fv=%b pass=%b exp 2/5/1/0",
                  ia.mismatch_cnt, ia.first_fail, ia.fail_valid, ia.pass);
      end
      ia.rd_addr = 4'd5;
      #1;
      checks++;
      if (ia.rd_data !== 5'h05) begin
         failures++; $display("FAIL mm_rd5 got=%h exp=05", ia.rd_data);
      end
      wr(0, 4'd5, 5'h05);
      wr(0, 4'd9, 5'h09);
   endtask

   task automatic test_settle();
      int lat;
      logic b0, dn;
      load_id(1);
      run(1, 0, lat, b0, dn);
      checks++;
      if (lat != 80) begin
         failures++; $display("FAIL settle3_lat got=%0d exp=80", lat);
      end
      checks++;
      if (ib.pass !== 1'b1 || ib.mismatch_cnt !== 5'd0) begin
         failures++;
         $display("FAIL settle3_pass pass=%b cnt=%0d exp 1/0", ib.pass,
                  ib.mismatch_cnt);
      end
      dly_sel = 1'b1;
      run(0, 0, lat, b0, dn);
      checks++;
      if (ia.pass !== 1'b0 || ia.fail_valid !== 1'b1) begin
         failures++;
         $display("FAIL settle1_dly pass=%b fv=%b exp 0/1", ia.pass,
                  ia.fail_valid);
      end
      dly_sel = 1'b0;
   endtask

   task automatic test_back_to_back();
      int lat;
      logic b0, dn;
      run(0, 1, lat, b0, dn);
      checks++;
      if (lat != 48 || dn !== 1'b0) begin
         failures++;
         $display("FAIL b2b_lat got=%0d done_nx=%b exp 48/0", lat, dn);
      end
      checks++;
      if (ia.pass !== 1'b1 || ia.mismatch_cnt !== 5'd0) begin
         failures++;
         $display("FAIL b2b_pass pass=%b cnt=%0d exp 1/0", ia.pass,
                  ia.mismatch_cnt);
      end
      run(0, 0, lat, b0, dn);
      checks++;
      if (ia.pass !== 1'b1) begin
         failures++; $display("FAIL b2b_gold15 pass=%b exp 1", ia.pass);
      end
   endtask

   task automatic test_start_write();
      int lat;
      logic b0, dn;
      run(0, 2, lat, b0, dn);
      checks++;
      if (lat != 48 || ia.mismatch_cnt !== 5'd1 ||
          ia.first_fail !== 4'd3 || ia.pass !== 1'b0) begin
         failures++;
         $display("FAIL sw_status lat=%0d cnt=%0d ff=%0d pass=%b exp 48/1/3/0",
                  lat, ia.mismatch_cnt, ia.first_fail, ia.pass);
      end
      wr(0, 4'd3, 5'h03);
   endtask

   task automatic test_abort();
      int lat;
      logic b0, dn;
      logic seen;
      wr(0, 4'd5, 5'h1F);
      @(negedge clk);
      ia.start = 1'b1;
      @(posedge clk);
      #1;
      ia.start = 1'b0;
      repeat (23) @(negedge clk);
      ia.abort = 1'b1;
      @(negedge clk);
      ia.abort = 1'b0;
      checks++;
      if (ia.busy !== 1'b0) begin
         failures++; $display("FAIL abort_busy got=%b exp 0", ia.busy);
      end
      seen = ia.done;
      repeat (20) begin
         @(negedge clk);
         if (ia.done) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++; $display("FAIL abort_done got=%b exp 0", seen);
      end
      checks++;
      if (ia.pass !== 1'b0 || ia.mismatch_cnt !== 5'd1 ||
          ia.first_fail !== 4'd5 || ia.fail_valid !== 1'b1) begin
         failures++;
         $display("FAIL abort_partial pass=%b cnt=%0d ff=%0d fv=%b",
                  ia.pass, ia.mismatch_cnt, ia.first_fail, ia.fail_valid);
      end
      ia.rd_addr = 4'd6;
      #1;
      checks++;
      if (ia.rd_data !== 5'h06) begin
         failures++; $display("FAIL abort_rd6 got=%h exp=06", ia.rd_data);
      end
      wr(0, 4'd5, 5'h05);
      run(0, 0, lat, b0, dn);
      checks++;
      if (lat != 48 || ia.pass !== 1'b1) begin
         failures++;
         $display("FAIL abort_rerun lat=%0d pass=%b exp 48/1", lat, ia.pass);
      end
   endtask

   task automatic test_rst_mid();
      int lat;
      int bad;
      logic b0, dn;
      wr(0, 4'd5, 5'h1F);
      @(negedge clk);
      ia.start = 1'b1;
      @(posedge clk);
      #1;
      ia.start = 1'b0;
      repeat (23) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (ia.busy !== 1'b0 || ia.cut_x !== 4'd0 ||
          ia.mismatch_cnt !== 5'd0 || ia.fail_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid busy=%b x=%h cnt=%0d fv=%b exp all 0",
                  ia.busy, ia.cut_x, ia.mismatch_cnt, ia.fail_valid);
      end
      bad = 0;
      for (int a = 0; a < 16; a++) begin
         ia.rd_addr = 4'(a);
         #0.1;
         if (ia.rd_data !== 5'd0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++; $display("FAIL rst_mid_rd nonzero=%0d exp=0", bad);
      end
      @(negedge clk);
      rst = 1'b0;
      run(0, 0, lat, b0, dn);
      checks++;
      if (ia.mismatch_cnt !== 5'd15 || ia.first_fail !== 4'd1 ||
          ia.pass !== 1'b0) begin
         failures++;
         $display("FAIL rst_gold_clr cnt=%0d ff=%0d pass=%b exp 15/1/0",
                  ia.mismatch_cnt, ia.first_fail, ia.pass);
      end
   endtask

   initial begin
      ia.start = 1'b0; ia.abort = 1'b0; ia.exp_we = 1'b0;
      ia.exp_addr = '0; ia.exp_data = '0; ia.rd_addr = '0;
      ib.start = 1'b0; ib.abort = 1'b0; ib.exp_we = 1'b0;
      ib.exp_addr = '0; ib.exp_data = '0; ib.rd_addr = '0;
      test_reset();
      test_basic();
      test_mismatch();
      test_settle();
      test_back_to_back();
      test_start_write();
      test_abort();
      test_rst_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
